// File: rtl/data_mem_arbiter_pkg.sv
// Shared types and helpers for the data-memory arbiter: FSM state encoding,
// access-size encodings and the size-to-byte-count conversion.
package dmem_arb_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_WAIT = 3'd1,
        WR_ADDR = 3'd2,
        WR_DATA = 3'd3,
        RESPOND = 3'd4,
        ERROR   = 3'd5
    } arb_state_e;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;
    localparam logic [1:0] SZ_D = 2'd3;

    // Number of bytes touched by an access of the given size encoding.
    function automatic logic [3:0] size_bytes(input logic [1:0] size);
        logic [3:0] bytes;
        case (size)
            SZ_B:    bytes = 4'd1;
            SZ_H:    bytes = 4'd2;
            SZ_W:    bytes = 4'd4;
            SZ_D:    bytes = 4'd8;
            default: bytes = 4'd8;
        endcase
        return bytes;
    endfunction

endpackage

// File: rtl/data_mem_arbiter_if.sv
// Bus bundles around the data-memory arbiter.
//  dmem_req_if : requester side (CPU fetch / load-store FSMs) plus the legal
//                address window. master = requesters, slave = arbiter.
//  dmem_mem_if : AXI-master request side. master = arbiter, slave = AXI master.
interface dmem_req_if #(
    parameter int N_REQ  = 2,
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
);
    logic [N_REQ-1:0]        req_valid;
    logic [N_REQ-1:0]        req_write;
    logic [N_REQ*ADDR_W-1:0] req_addr;
    logic [N_REQ*2-1:0]      req_size;
    logic [N_REQ*DATA_W-1:0] req_wdata;
    logic [N_REQ-1:0]        req_done;
    logic                    req_err;
    logic [DATA_W-1:0]       req_rdata;
    logic [ADDR_W-1:0]       dm_bottom;
    logic [ADDR_W-1:0]       dm_top;

    modport master (
        output req_valid, req_write, req_addr, req_size, req_wdata,
               dm_bottom, dm_top,
        input  req_done, req_err, req_rdata
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_size, req_wdata,
               dm_bottom, dm_top,
        output req_done, req_err, req_rdata
    );
endinterface

interface dmem_mem_if #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
);
    logic              mem_read_request;
    logic              mem_write_request;
    logic [ADDR_W-1:0] mem_address;
    logic [1:0]        mem_size_select;
    logic [DATA_W-1:0] mem_write_data;
    logic [DATA_W-1:0] mem_read_data;
    logic              mem_read_ready;
    logic              mem_write_ready;
    logic              mem_write_finished;

    modport master (
        output mem_read_request, mem_write_request, mem_address,
               mem_size_select, mem_write_data,
        input  mem_read_data, mem_read_ready, mem_write_ready,
               mem_write_finished
    );

    modport slave (
        input  mem_read_request, mem_write_request, mem_address,
               mem_size_select, mem_write_data,
        output mem_read_data, mem_read_ready, mem_write_ready,
               mem_write_finished
    );
endinterface

// File: rtl/data_mem_arbiter_rr_arbiter.sv
// Combinational rotate-priority picker. Searches the request vector starting
// one position after the last granted port, wrapping around, and returns the
// first hit as a one-hot vector and an index. Holds no state.
module rr_arbiter #(
    parameter int N_REQ = 2,
    parameter int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] last_grant,
    output logic [N_REQ-1:0] grant_oh,
    output logic [IDX_W-1:0] grant_idx,
    output logic             grant_any
);

    int cand_s;

    // Rotating first-set search starting after last_grant.
    always_comb begin
        grant_oh  = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        cand_s    = 0;
        for (int off = 1; off <= N_REQ; off++) begin
            cand_s = int'(last_grant) + off;
            if (cand_s >= N_REQ) begin
                cand_s = cand_s - N_REQ;
            end else begin
                cand_s = cand_s;
            end
            if (!grant_any && req[cand_s[IDX_W-1:0]]) begin
                grant_any                   = 1'b1;
                grant_oh[cand_s[IDX_W-1:0]] = 1'b1;
                grant_idx                   = cand_s[IDX_W-1:0];
            end else begin
                grant_any = grant_any;
            end
        end
    end

endmodule

// File: rtl/data_mem_arbiter.sv
// Data-memory arbiter: shares one AXI-master request port between N_REQ
// requesters with round-robin grant, one transaction in flight, an address
// window check and a per-transaction timeout. All outputs are registered.
module data_mem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int N_REQ   = 2,
    parameter int ADDR_W  = 64,
    parameter int DATA_W  = 64,
    parameter int TIMEOUT = 1024
) (
    input  logic       clk,
    input  logic       rst,
    dmem_req_if.slave  req_bus,
    dmem_mem_if.master mem_bus
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [IDX_W-1:0] LAST_PORT = IDX_W'(N_REQ - 1);
    localparam logic [CNT_W-1:0] TMO_LAST  = CNT_W'(TIMEOUT - 1);

    arb_state_e        state_r;
    logic [IDX_W-1:0]  last_grant_r;
    logic [IDX_W-1:0]  grant_r;
    logic [N_REQ-1:0]  grant_oh_r;
    logic [CNT_W-1:0]  tmo_cnt_r;

    logic [N_REQ-1:0]  grant_oh_s;
    logic [IDX_W-1:0]  grant_idx_s;
    logic              grant_any_s;

    logic [ADDR_W-1:0] sel_addr_s;
    logic [1:0]        sel_size_s;
    logic [DATA_W-1:0] sel_wdata_s;
    logic              sel_write_s;
    logic [ADDR_W:0]   len_s;
    logic [ADDR_W:0]   last_byte_s;
    logic              oob_s;
    logic              tmo_hit_s;
    logic [CNT_W-1:0]  tmo_sat_inc_s;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_rr_arbiter (
        .req        (req_bus.req_valid),
        .last_grant (last_grant_r),
        .grant_oh   (grant_oh_s),
        .grant_idx  (grant_idx_s),
        .grant_any  (grant_any_s)
    );

    // One-hot mux of the winning port's request fields.
    always_comb begin
        sel_addr_s  = '0;
        sel_size_s  = 2'd0;
        sel_wdata_s = '0;
        sel_write_s = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            sel_addr_s  = sel_addr_s  | (req_bus.req_addr[i*ADDR_W +: ADDR_W]  & {ADDR_W{grant_oh_s[i]}});
            sel_size_s  = sel_size_s  | (req_bus.req_size[i*2 +: 2]            & {2{grant_oh_s[i]}});
            sel_wdata_s = sel_wdata_s | (req_bus.req_wdata[i*DATA_W +: DATA_W] & {DATA_W{grant_oh_s[i]}});
            sel_write_s = sel_write_s | (req_bus.req_write[i] & grant_oh_s[i]);
        end
    end

    // Window check; the extra top bit makes an access that wraps past the
    // end of the address space compare as out of range.
    always_comb begin
        len_s       = {{(ADDR_W-3){1'b0}}, size_bytes(sel_size_s)};
        last_byte_s = {1'b0, sel_addr_s} + len_s - {{ADDR_W{1'b0}}, 1'b1};
        oob_s       = (sel_addr_s < req_bus.dm_bottom) ||
                      (last_byte_s > {1'b0, req_bus.dm_top});
    end

    // Timeout helpers: terminal-count flag and a saturating increment so a
    // late write-address accept cannot wrap the budget back to zero.
    always_comb begin
        tmo_hit_s = (tmo_cnt_r == TMO_LAST);
        if (tmo_hit_s) begin
            tmo_sat_inc_s = tmo_cnt_r;
        end else begin
            tmo_sat_inc_s = tmo_cnt_r + CNT_W'(1'b1);
        end
    end

    // Transaction FSM; owns every register and drives all outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r                   <= IDLE;
            last_grant_r              <= LAST_PORT;
            grant_r                   <= '0;
            grant_oh_r                <= '0;
            tmo_cnt_r                 <= '0;
            req_bus.req_done          <= '0;
            req_bus.req_err           <= 1'b0;
            req_bus.req_rdata         <= '0;
            mem_bus.mem_read_request  <= 1'b0;
            mem_bus.mem_write_request <= 1'b0;
            mem_bus.mem_address       <= '0;
            mem_bus.mem_size_select   <= 2'd0;
            mem_bus.mem_write_data    <= '0;
        end else begin
            // Completion outputs are single-cycle pulses unless set below.
            req_bus.req_done  <= '0;
            req_bus.req_err   <= 1'b0;
            req_bus.req_rdata <= '0;
            case (state_r)
                IDLE: begin
                    if (grant_any_s) begin
                        grant_r                 <= grant_idx_s;
                        grant_oh_r              <= grant_oh_s;
                        tmo_cnt_r               <= '0;
                        mem_bus.mem_address     <= sel_addr_s;
                        mem_bus.mem_size_select <= sel_size_s;
                        mem_bus.mem_write_data  <= sel_wdata_s;
                        if (oob_s) begin
                            // Rejected without touching memory.
                            req_bus.req_done <= grant_oh_s;
                            req_bus.req_err  <= 1'b1;
                            state_r          <= ERROR;
                        end else if (sel_write_s) begin
                            mem_bus.mem_write_request <= 1'b1;
                            state_r                   <= WR_ADDR;
                        end else begin
                            mem_bus.mem_read_request <= 1'b1;
                            state_r                  <= RD_WAIT;
                        end
                    end else begin
                        state_r <= IDLE;
                    end
                end
                RD_WAIT: begin
                    if (mem_bus.mem_read_ready) begin
                        mem_bus.mem_read_request <= 1'b0;
                        req_bus.req_done         <= grant_oh_r;
                        req_bus.req_rdata        <= mem_bus.mem_read_data;
                        state_r                  <= RESPOND;
                    end else if (tmo_hit_s) begin
                        mem_bus.mem_read_request <= 1'b0;
                        req_bus.req_done         <= grant_oh_r;
                        req_bus.req_err          <= 1'b1;
                        state_r                  <= ERROR;
                    end else begin
                        tmo_cnt_r <= tmo_sat_inc_s;
                    end
                end
                WR_ADDR: begin
                    if (mem_bus.mem_write_ready) begin
                        tmo_cnt_r <= tmo_sat_inc_s;
                        state_r   <= WR_DATA;
                    end else if (tmo_hit_s) begin
                        mem_bus.mem_write_request <= 1'b0;
                        req_bus.req_done          <= grant_oh_r;
                        req_bus.req_err           <= 1'b1;
                        state_r                   <= ERROR;
                    end else begin
                        tmo_cnt_r <= tmo_sat_inc_s;
                    end
                end
                WR_DATA: begin
                    if (mem_bus.mem_write_finished) begin
                        mem_bus.mem_write_request <= 1'b0;
                        req_bus.req_done          <= grant_oh_r;
                        state_r                   <= RESPOND;
                    end else if (tmo_hit_s) begin
                        mem_bus.mem_write_request <= 1'b0;
                        req_bus.req_done          <= grant_oh_r;
                        req_bus.req_err           <= 1'b1;
                        state_r                   <= ERROR;
                    end else begin
                        tmo_cnt_r <= tmo_sat_inc_s;
                    end
                end
                RESPOND: begin
                    // Bubble cycle: no arbitration while req_done is visible.
                    last_grant_r <= grant_r;
                    state_r      <= IDLE;
                end
                ERROR: begin
                    last_grant_r <= grant_r;
                    state_r      <= IDLE;
                end
                default: begin
                    mem_bus.mem_read_request  <= 1'b0;
                    mem_bus.mem_write_request <= 1'b0;
                    state_r                   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed bench for data_mem_arbiter: reset state, reads, round-robin
// fairness, writes, window errors, timeout and mid-transaction reset.
module tb_data_mem_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks   = 0;
    int   failures = 0;

    dmem_req_if #(.N_REQ(2), .ADDR_W(64), .DATA_W(64)) rbus ();
    dmem_mem_if #(.ADDR_W(64), .DATA_W(64))            mbus ();

    data_mem_arbiter #(
        .N_REQ   (2),
        .ADDR_W  (64),
        .DATA_W  (64),
        .TIMEOUT (16)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .req_bus (rbus),
        .mem_bus (mbus)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_port(input int p, input logic v, input logic w,
                            input logic [63:0] a, input logic [1:0] sz,
                            input logic [63:0] wd);
        rbus.req_valid[p]         = v;
        rbus.req_write[p]         = w;
        rbus.req_addr[p*64 +: 64] = a;
        rbus.req_size[p*2 +: 2]   = sz;
        rbus.req_wdata[p*64 +: 64] = wd;
    endtask

    // Wait (bounded) for a read request, answer it at once, check completion.
    task automatic serve_read(input string tag, input logic [63:0] exp_addr,
                              input logic [63:0] data, input logic [1:0] exp_done);
        int n;
        n = 0;
        while (!mbus.mem_read_request && n < 20) begin
            tick();
            n++;
        end
        chk({tag, "_rdreq"}, 64'(mbus.mem_read_request), 64'd1);
        chk({tag, "_addr"}, mbus.mem_address, exp_addr);
        mbus.mem_read_ready = 1'b1;
        mbus.mem_read_data  = data;
        tick();
        mbus.mem_read_ready = 1'b0;
        chk({tag, "_done"}, 64'(rbus.req_done), 64'(exp_done));
        chk({tag, "_rdata"}, rbus.req_rdata, data);
        chk({tag, "_err"}, 64'(rbus.req_err), 64'd0);
        tick();
    endtask

    initial begin
        int n;
        rbus.req_valid = '0;
        rbus.req_write = '0;
        rbus.req_addr  = '0;
        rbus.req_size  = '0;
        rbus.req_wdata = '0;
        rbus.dm_bottom = 64'h0;
        rbus.dm_top    = 64'hFFFF;
        mbus.mem_read_data      = 64'h0;
        mbus.mem_read_ready     = 1'b0;
        mbus.mem_write_ready    = 1'b0;
        mbus.mem_write_finished = 1'b0;

        // Reset state
        tick();
        tick();
        chk("rst_done", 64'(rbus.req_done), 64'd0);
        chk("rst_err", 64'(rbus.req_err), 64'd0);
        chk("rst_rdata", rbus.req_rdata, 64'd0);
        chk("rst_rdreq", 64'(mbus.mem_read_request), 64'd0);
        chk("rst_wrreq", 64'(mbus.mem_write_request), 64'd0);
        chk("rst_addr", mbus.mem_address, 64'd0);
        rst = 1'b0;

        // 1: port0 read, ready two cycles after the request appears
        set_port(0, 1'b1, 1'b0, 64'h1000, 2'd3, 64'h0);
        tick();
        chk("t1_rdreq", 64'(mbus.mem_read_request), 64'd1);
        chk("t1_addr", mbus.mem_address, 64'h1000);
        chk("t1_size", 64'(mbus.mem_size_select), 64'd3);
        tick();
        chk("t1_rdreq_hold", 64'(mbus.mem_read_request), 64'd1);
        chk("t1_nodone", 64'(rbus.req_done), 64'd0);
        mbus.mem_read_ready = 1'b1;
        mbus.mem_read_data  = 64'hDEADBEEF;
        tick();
        mbus.mem_read_ready = 1'b0;
        chk("t1_done", 64'(rbus.req_done), 64'd1);
        chk("t1_rdata", rbus.req_rdata, 64'hDEADBEEF);
        chk("t1_err", 64'(rbus.req_err), 64'd0);
        chk("t1_rdreq_drop", 64'(mbus.mem_read_request), 64'd0);
        set_port(0, 1'b0, 1'b0, 64'h0, 2'd0, 64'h0);
        tick();
        chk("t1_done_pulse", 64'(rbus.req_done), 64'd0);

        // 2: both ports requesting continuously from reset -> 0, 1, 0
        rst = 1'b1;
        tick();
        rst = 1'b0;
        set_port(0, 1'b1, 1'b0, 64'h100, 2'd2, 64'h0);
        set_port(1, 1'b1, 1'b0, 64'h200, 2'd2, 64'h0);
        serve_read("t2a", 64'h100, 64'h11, 2'b01);
        serve_read("t2b", 64'h200, 64'h22, 2'b10);
        serve_read("t2c", 64'h100, 64'h33, 2'b01);
        set_port(0, 1'b0, 1'b0, 64'h0, 2'd0, 64'h0);
        set_port(1, 1'b0, 1'b0, 64'h0, 2'd0, 64'h0);

        // 3: port1 write
        set_port(1, 1'b1, 1'b1, 64'h2000, 2'd2, 64'h55);
        tick();
        chk("t3_wrreq", 64'(mbus.mem_write_request), 64'd1);
        chk("t3_wdata", mbus.mem_write_data, 64'h55);
        chk("t3_addr", mbus.mem_address, 64'h2000);
        chk("t3_rdreq", 64'(mbus.mem_read_request), 64'd0);
        mbus.mem_write_ready = 1'b1;
        tick();
        mbus.mem_write_ready = 1'b0;
        chk("t3_wrreq_wrdata", 64'(mbus.mem_write_request), 64'd1);
        tick();
        chk("t3_wrreq_hold", 64'(mbus.mem_write_request), 64'd1);
        chk("t3_nodone", 64'(rbus.req_done), 64'd0);
        mbus.mem_write_finished = 1'b1;
        tick();
        mbus.mem_write_finished = 1'b0;
        chk("t3_done", 64'(rbus.req_done), 64'd2);
        chk("t3_err", 64'(rbus.req_err), 64'd0);
        chk("t3_rdata", rbus.req_rdata, 64'd0);
        chk("t3_wrreq_drop", 64'(mbus.mem_write_request), 64'd0);
        set_port(1, 1'b0, 1'b0, 64'h0, 2'd0, 64'h0);
        tick();

        // 4: window checks
        rbus.dm_top = 64'h1FFF;
        set_port(0, 1'b1, 1'b1, 64'h1FFE, 2'd2, 64'h77);
        tick();
        chk("t4_span_done", 64'(rbus.req_done), 64'd1);
        chk("t4_span_err", 64'(rbus.req_err), 64'd1);
        chk("t4_span_wrreq", 64'(mbus.mem_write_request), 64'd0);
        set_port(0, 1'b0, 1'b0, 64'h0, 2'd0, 64'h0);
        tick();
        chk("t4_err_pulse", 64'(rbus.req_err), 64'd0);
        chk("t4_wrreq_never", 64'(mbus.mem_write_request), 64'd0);
        // last byte exactly at dm_top is legal
        set_port(0, 1'b1, 1'b1, 64'h1FFC, 2'd2, 64'h78);
        tick();
        chk("t4_edge_wrreq", 64'(mbus.mem_write_request), 64'd1);
        mbus.mem_write_ready = 1'b1;
        tick();
        mbus.mem_write_ready    = 1'b0;
        mbus.mem_write_finished = 1'b1;
        tick();
        mbus.mem_write_finished = 1'b0;
        chk("t4_edge_done", 64'(rbus.req_done), 64'd1);
        chk("t4_edge_err", 64'(rbus.req_err), 64'd0);
        set_port(0, 1'b0, 1'b0, 64'h0, 2'd0, 64'h0);
        tick();
        // below dm_bottom
        rbus.dm_bottom = 64'h100;
        set_port(0, 1'b1, 1'b0, 64'hFF, 2'd0, 64'h0);
        tick();
        chk("t4_low_err", 64'(rbus.req_err), 64'd1);
        chk("t4_low_rdreq", 64'(mbus.mem_read_request), 64'd0);
        set_port(0, 1'b0, 1'b0, 64'h0, 2'd0, 64'h0);
        tick();
        // wrap past the top of the address space
        rbus.dm_bottom = 64'h0;
        rbus.dm_top    = 64'hFFFF_FFFF_FFFF_FFFF;
        set_port(0, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 2'd1, 64'h0);
        tick();
        chk("t4_wrap_err", 64'(rbus.req_err), 64'd1);
        chk("t4_wrap_done", 64'(rbus.req_done), 64'd1);
        set_port(0, 1'b0, 1'b0, 64'h0, 2'd0, 64'h0);
        tick();
        rbus.dm_top = 64'hFFFF;

        // 5a: read timeout, request high for exactly 16 cycles
        set_port(0, 1'b1, 1'b0, 64'h300, 2'd3, 64'h0);
        tick();
        n = 0;
        while (mbus.mem_read_request && n < 40) begin
            n++;
            tick();
        end
        chk("t5_tmo_cycles", 64'(n), 64'd16);
        chk("t5_tmo_done", 64'(rbus.req_done), 64'd1);
        chk("t5_tmo_err", 64'(rbus.req_err), 64'd1);
        chk("t5_tmo_rdata", rbus.req_rdata, 64'd0);
        set_port(0, 1'b0, 1'b0, 64'h0, 2'd0, 64'h0);
        tick();
        // 5b: ready in the 16th cycle wins over the timeout
        set_port(0, 1'b1, 1'b0, 64'h308, 2'd3, 64'h0);
        tick();
        for (int i = 0; i < 15; i++) begin
            tick();
        end
        chk("t5_c16_rdreq", 64'(mbus.mem_read_request), 64'd1);
        mbus.mem_read_ready = 1'b1;
        mbus.mem_read_data  = 64'hCAFE;
        tick();
        mbus.mem_read_ready = 1'b0;
        chk("t5_c16_done", 64'(rbus.req_done), 64'd1);
        chk("t5_c16_err", 64'(rbus.req_err), 64'd0);
        chk("t5_c16_rdata", rbus.req_rdata, 64'hCAFE);
        set_port(0, 1'b0, 1'b0, 64'h0, 2'd0, 64'h0);
        tick();

        // 6: reset during WR_DATA, then port0 wins over port1 again
        set_port(1, 1'b1, 1'b1, 64'h2000, 2'd3, 64'hA5A5);
        tick();
        mbus.mem_write_ready = 1'b1;
        tick();
        mbus.mem_write_ready = 1'b0;
        chk("t6_wrreq_before", 64'(mbus.mem_write_request), 64'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("t6_rst_wrreq", 64'(mbus.mem_write_request), 64'd0);
        chk("t6_rst_addr", mbus.mem_address, 64'd0);
        chk("t6_rst_wdata", mbus.mem_write_data, 64'd0);
        chk("t6_rst_size", 64'(mbus.mem_size_select), 64'd0);
        chk("t6_rst_done", 64'(rbus.req_done), 64'd0);
        set_port(1, 1'b0, 1'b0, 64'h0, 2'd0, 64'h0);
        tick();
        tick();
        rst = 1'b0;
        set_port(0, 1'b1, 1'b0, 64'h400, 2'd3, 64'h0);
        set_port(1, 1'b1, 1'b0, 64'h500, 2'd3, 64'h0);
        serve_read("t6_after", 64'h400, 64'h1234, 2'b01);
        set_port(0, 1'b0, 1'b0, 64'h0, 2'd0, 64'h0);
        set_port(1, 1'b0, 1'b0, 64'h0, 2'd0, 64'h0);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
